// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the unified memory port between CPU and debug requesters
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] LAT_LD     = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state, state_nxt;
    logic              grant_cpu, grant_dbg;
    logic              lat_we, win_dbg;
    logic [3:0]        wait_cnt, starve_cnt;
    logic              last_wait;

    assign last_wait = (state == S_WAIT) && (wait_cnt == 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_cpu = 1'b0;
        grant_dbg = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        cpu_done  = 1'b0;
        dbg_done  = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                // Debug only overrides the CPU once it has been passed over STARVE_MAX times.
                if (dbg_req && (starve_cnt == STARVE_LIM)) grant_dbg = 1'b1;
                else if (cpu_req)                          grant_cpu = 1'b1;
                else if (dbg_req)                          grant_dbg = 1'b1;
                if (grant_cpu || grant_dbg) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = lat_we;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == 4'd1) state_nxt = S_RESP;
            end
            S_RESP: begin
                cpu_done  = !win_dbg;
                dbg_done  = win_dbg;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we     <= 1'b0;
            win_dbg    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wait_cnt   <= 4'd0;
            starve_cnt <= 4'd0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            if (grant_cpu) begin
                lat_we    <= cpu_we;
                win_dbg   <= 1'b0;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end else if (grant_dbg) begin
                lat_we    <= dbg_we;
                win_dbg   <= 1'b1;
                mem_addr  <= dbg_addr;
                mem_wdata <= dbg_wdata;
            end

            if (state == S_ISSUE)     wait_cnt <= LAT_LD;
            else if (state == S_WAIT) wait_cnt <= wait_cnt - 4'd1;

            if (state == S_IDLE) begin
                if (grant_dbg || !dbg_req)
                    starve_cnt <= 4'd0;
                else if (grant_cpu && (starve_cnt != STARVE_LIM))
                    starve_cnt <= starve_cnt + 4'd1;
            end

            if (last_wait && !lat_we) begin
                if (win_dbg) dbg_rdata <= mem_rdata;
                else         cpu_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LAT   = 1;
    localparam int LAT_B = 3;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
    logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_done, dbg_done, mem_en, mem_we, busy;

    logic        b_rst = 1'b1;
    logic        b_cpu_req = 1'b0, b_cpu_we = 1'b0;
    logic [31:0] b_cpu_addr = '0, b_cpu_wdata = '0;
    logic [31:0] b_cpu_rdata, b_dbg_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_cpu_done, b_dbg_done, b_mem_en, b_mem_we, b_busy;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
        .clk(clk), .rst(a_rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_B), .STARVE_MAX(SMAX)) u_dut_b (
        .clk(clk), .rst(b_rst),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_rdata(b_cpu_rdata), .cpu_done(b_cpu_done),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(32'h0), .dbg_wdata(32'h0),
        .dbg_rdata(b_dbg_rdata), .dbg_done(b_dbg_done),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Never-written words read back as a fixed pattern so the reference can predict them.
    function automatic logic [31:0] dflt(input logic [7:0] i);
        return {24'hC0FFEE, i};
    endfunction

    bit [31:0] mem_a [256];
    bit        mem_av [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_a[mem_addr[9:2]]  <= mem_wdata;
                mem_av[mem_addr[9:2]] <= 1'b1;
            end
            mem_rdata <= mem_av[mem_addr[9:2]] ? mem_a[mem_addr[9:2]] : dflt(mem_addr[9:2]);
        end
    end

    logic [31:0] mem_b [256];
    logic [31:0] rb0, rb1, rb2;
    always @(posedge clk) begin
        if (b_mem_en) begin
            if (b_mem_we) mem_b[b_mem_addr[9:2]] <= b_mem_wdata;
            rb0 <= mem_b[b_mem_addr[9:2]];
        end
        rb1 <= rb0;
        rb2 <= rb1;
    end
    assign b_mem_rdata = rb2;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_en(output int k);
        k = 0;
        do begin @(negedge clk); k++; end while (!mem_en && k < 12);
    endtask

    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(negedge clk); k++;
            chk("no_mem_strobe_outside_issue", {mem_en, mem_we}, 0);
        end while (!(cpu_done || dbg_done) && k < 12);
    endtask

    task automatic b_wait_en(output int k);
        k = 0;
        do begin @(negedge clk); k++; end while (!b_mem_en && k < 12);
    endtask

    task automatic b_wait_done(output int k);
        k = 0;
        do begin @(negedge clk); k++; end while (!b_cpu_done && k < 12);
    endtask

    task automatic a_txn(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd);
        logic [31:0] c0, d0;
        int k;
        @(negedge clk);
        c0 = cpu_rdata;
        d0 = dbg_rdata;
        if (!port) begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
        else       begin dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; end
        wait_en(k);
        chk("issue_latency", k, 1);
        chk("issue_addr", mem_addr, addr);
        chk("issue_we", mem_we, we);
        if (we) chk("issue_wdata", mem_wdata, wdata);
        wait_done(k);
        chk("done_latency", k, LAT + 1);
        chk("done_cpu", cpu_done, !port);
        chk("done_dbg", dbg_done, port);
        chk("resp_addr_hold", mem_addr, addr);
        if (!port) begin
            cpu_req = 0;
            chk("cpu_rdata", cpu_rdata, we ? c0 : exp_rd);
            chk("dbg_rdata_untouched", dbg_rdata, d0);
        end else begin
            dbg_req = 0;
            chk("dbg_rdata", dbg_rdata, we ? d0 : exp_rd);
            chk("cpu_rdata_untouched", cpu_rdata, c0);
        end
        @(negedge clk);
        chk("idle_after_resp", {busy, cpu_done, dbg_done}, 0);
        chk("rdata_held", port ? dbg_rdata : cpu_rdata, port ? (we ? d0 : exp_rd) : (we ? c0 : exp_rd));
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [10];

    // Reference-model state for the randomized phase
    bit [31:0] ref_mem [256];
    bit        ref_av [256];

    initial begin
        int k;
        int starve, next_arb, issue_c, done_c;
        bit cur_dbg, cur_we, gc, gd;
        logic [31:0] cur_addr, cur_wdata, cur_rd, exp_cpu_rd, exp_dbg_rd;
        logic [7:0] idx;
        bit e_iss, e_done, in_txn;

        tbl[0] = '{1'b1, 1'b1, 32'h040, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 32'h040, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b1, 32'h100, 32'h12345678, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 32'h100, 32'h0,        32'h12345678};
        tbl[4] = '{1'b0, 1'b1, 32'h010, 32'hA5A50010, 32'h0};
        tbl[5] = '{1'b1, 1'b1, 32'h020, 32'h5A5A0020, 32'h0};
        tbl[6] = '{1'b1, 1'b0, 32'h010, 32'h0,        32'hA5A50010};
        tbl[7] = '{1'b0, 1'b0, 32'h020, 32'h0,        32'h5A5A0020};
        tbl[8] = '{1'b0, 1'b1, 32'h3FC, 32'hFFFFFFFF, 32'h0};
        tbl[9] = '{1'b1, 1'b0, 32'h3FC, 32'h0,        32'hFFFFFFFF};

        repeat (2) @(negedge clk);
        chk("rst_strobes", {mem_en, mem_we, cpu_done, dbg_done, busy}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
        chk("rst_b_outputs", {b_mem_en, b_mem_we, b_cpu_done, b_dbg_done, b_busy, b_mem_addr, b_dbg_rdata}, 0);
        a_rst = 0;
        b_rst = 0;

        for (int i = 0; i < 10; i++)
            a_txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd);

        // Simultaneous requests: CPU first, debug after one IDLE cycle
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
        wait_en(k);
        chk("both_first_latency", k, 1);
        chk("both_first_addr", mem_addr, 32'h10);
        wait_done(k);
        chk("both_cpu_done", {cpu_done, dbg_done}, 2'b10);
        chk("both_cpu_rdata", cpu_rdata, 32'hA5A50010);
        chk("both_dbg_rdata_held", dbg_rdata, 32'hFFFFFFFF);
        cpu_req = 0;
        wait_en(k);
        chk("both_second_latency", k, 2);
        chk("both_second_addr", mem_addr, 32'h20);
        wait_done(k);
        chk("both_dbg_done", {cpu_done, dbg_done}, 2'b01);
        chk("both_dbg_rdata", dbg_rdata, 32'h5A5A0020);
        dbg_req = 0;

        // Starvation: both held, every fifth grant goes to debug
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h100;
        for (int g = 0; g < 10; g++) begin
            wait_en(k);
            chk("starve_grant_order", mem_addr, (g % 5 == 4) ? 32'h100 : 32'h40);
        end
        cpu_req = 0; dbg_req = 0;
        repeat (6) @(negedge clk);
        chk("starve_drained", busy, 0);

        // Address changes after grant are ignored
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        wait_en(k);
        chk("chg_issue_addr", mem_addr, 32'h40);
        @(negedge clk);
        cpu_addr = 32'h80;
        chk("chg_wait_addr", mem_addr, 32'h40);
        wait_done(k);
        chk("chg_resp_addr", mem_addr, 32'h40);
        chk("chg_rdata", cpu_rdata, 32'hDEADBEEF);
        wait_en(k);
        chk("chg_next_latency", k, 2);
        chk("chg_next_addr", mem_addr, 32'h80);
        wait_done(k);
        cpu_req = 0; cpu_addr = 32'hC0;
        chk("chg_next_rdata", cpu_rdata, dflt(8'h20));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("chg_no_grant_after_drop", {mem_en, busy}, 0);
        end
        chk("chg_addr_kept", mem_addr, 32'h80);

        // Reset in the middle of a long-latency read on the second instance
        @(negedge clk);
        b_cpu_req = 1; b_cpu_we = 1; b_cpu_addr = 32'h40; b_cpu_wdata = 32'hCAFEF00D;
        b_wait_en(k);
        chk("b_wr_issue", {b_mem_we, b_mem_addr}, {1'b1, 32'h40});
        b_wait_done(k);
        chk("b_wr_done_latency", k, LAT_B + 1);
        b_cpu_req = 0;
        @(negedge clk);
        b_cpu_req = 1; b_cpu_we = 0;
        b_wait_en(k);
        chk("b_rd_issue_latency", k, 1);
        repeat (2) @(negedge clk);
        b_rst = 1;
        #1;
        chk("b_rst_strobes", {b_mem_en, b_mem_we, b_cpu_done, b_busy}, 0);
        chk("b_rst_data", {b_mem_addr, b_mem_wdata, b_cpu_rdata}, 0);
        b_cpu_req = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b_rst_no_done", {b_cpu_done, b_busy}, 0);
        end
        b_rst = 0;
        @(negedge clk);
        b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 32'h40;
        b_wait_en(k);
        chk("b_post_issue_latency", k, 1);
        b_wait_done(k);
        chk("b_post_done_latency", k, LAT_B + 1);
        chk("b_post_rdata", b_cpu_rdata, 32'hCAFEF00D);
        b_cpu_req = 0;

        // Randomized traffic against a transaction-schedule reference model
        @(negedge clk);
        a_rst = 1;
        @(negedge clk);
        a_rst = 0;
        starve = 0; next_arb = 0; issue_c = -100; done_c = -100;
        cur_dbg = 0; cur_we = 0; cur_addr = '0; cur_wdata = '0; cur_rd = '0;
        exp_cpu_rd = '0; exp_dbg_rd = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            e_iss  = (c == issue_c);
            e_done = (c == done_c);
            in_txn = (c >= issue_c) && (c <= done_c);
            if (e_done && !cur_we) begin
                if (cur_dbg) exp_dbg_rd = cur_rd;
                else         exp_cpu_rd = cur_rd;
            end
            chk("rnd_mem_en", mem_en, e_iss);
            chk("rnd_mem_we", mem_we, e_iss && cur_we);
            chk("rnd_busy", busy, in_txn);
            chk("rnd_done", {cpu_done, dbg_done}, {e_done && !cur_dbg, e_done && cur_dbg});
            if (in_txn) chk("rnd_mem_addr", mem_addr, cur_addr);
            if (in_txn && cur_we) chk("rnd_mem_wdata", mem_wdata, cur_wdata);
            chk("rnd_cpu_rdata", cpu_rdata, exp_cpu_rd);
            chk("rnd_dbg_rdata", dbg_rdata, exp_dbg_rd);

            if (cpu_req ? (cpu_done && ($urandom % 2 == 0)) : ($urandom % 3 == 0)) begin
                cpu_req = 1; cpu_we = 1'($urandom); cpu_wdata = $urandom;
                cpu_addr = {22'b0, 2'b10, 6'($urandom), 2'b00};
            end else if (cpu_req && cpu_done) cpu_req = 0;
            if (dbg_req ? (dbg_done && ($urandom % 2 == 0)) : ($urandom % 3 == 0)) begin
                dbg_req = 1; dbg_we = 1'($urandom); dbg_wdata = $urandom;
                dbg_addr = {22'b0, 2'b10, 6'($urandom), 2'b00};
            end else if (dbg_req && dbg_done) dbg_req = 0;

            if (c >= next_arb) begin
                gd = dbg_req && ((starve == SMAX) || !cpu_req);
                gc = cpu_req && !gd;
                if (gc && dbg_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
                else               starve = 0;
                if (gc || gd) begin
                    cur_dbg   = gd;
                    cur_we    = gd ? dbg_we : cpu_we;
                    cur_addr  = gd ? dbg_addr : cpu_addr;
                    cur_wdata = gd ? dbg_wdata : cpu_wdata;
                    idx       = cur_addr[9:2];
                    if (cur_we) begin
                        ref_mem[idx] = cur_wdata;
                        ref_av[idx]  = 1'b1;
                    end else begin
                        cur_rd = ref_av[idx] ? ref_mem[idx] : dflt(idx);
                    end
                    issue_c  = c + 1;
                    done_c   = c + 2 + LAT;
                    next_arb = done_c + 1;
                end else begin
                    next_arb = c + 1;
                end
            end
        end
        cpu_req = 0;
        dbg_req = 0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
